// File: rtl/saturn_bus_sequencer.sv
// Saturn nibble-bus sequencer: runs the 4-phase bus cycle from a program FIFO
// (writes) and a counted burst-read engine, and emits one-cycle debugger events.
module saturn_bus_sequencer #(
    parameter int PTR_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk_en,
    input  logic             i_stall,
    input  logic [3:0]       i_phases,
    input  logic             i_prog_valid,
    input  logic [4:0]       i_prog_data,
    output logic             o_prog_ready,
    input  logic             i_read_req,
    input  logic [CNT_W-1:0] i_read_count,
    output logic             o_read_ready,
    output logic             o_read_valid,
    output logic [3:0]       o_read_data,
    input  logic [3:0]       i_bus_nibble_in,
    output logic             o_bus_clk_en,
    output logic             o_bus_is_data,
    output logic [3:0]       o_bus_nibble_out,
    output logic             o_busy,
    output logic             o_error,
    output logic             o_dbg_valid,
    output logic [1:0]       o_dbg_action,
    output logic [3:0]       o_dbg_data
);
    localparam int DEPTH = 2 ** PTR_W;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    typedef struct packed {
        logic       is_cmd;
        logic [3:0] nibble;
    } prog_entry_t;

    prog_entry_t      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occupancy;
    logic [CNT_W-1:0] remaining;
    state_t           state;

    logic        step, phase_ok, fifo_empty, fifo_full, push, pop, read_accept;
    prog_entry_t head;

    assign step        = i_clk_en && !i_stall;
    assign phase_ok    = $onehot(i_phases);
    assign fifo_empty  = (occupancy == '0);
    assign fifo_full   = (occupancy == (PTR_W+1)'(DEPTH));
    assign push        = i_prog_valid && !fifo_full;
    assign pop         = step && phase_ok && (i_phases == 4'b0001) && !fifo_empty;
    assign read_accept = i_read_req && (remaining == '0);
    assign head        = fifo_mem[rd_ptr];

    assign o_prog_ready = !fifo_full;
    assign o_read_ready = (remaining == '0);
    assign o_busy       = !fifo_empty || (remaining != '0) || o_bus_clk_en;

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= prog_entry_t'(i_prog_data);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occupancy        <= '0;
            remaining        <= '0;
            state            <= IDLE;
            o_bus_clk_en     <= 1'b0;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= 4'h0;
            o_read_valid     <= 1'b0;
            o_read_data      <= 4'h0;
            o_error          <= 1'b0;
            o_dbg_valid      <= 1'b0;
            o_dbg_action     <= 2'b11;
            o_dbg_data       <= 4'h0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase

            o_read_valid <= 1'b0;
            o_dbg_valid  <= 1'b0;
            o_dbg_action <= 2'b11;
            o_dbg_data   <= 4'h0;

            // A zero-length burst is a protocol error and loads nothing.
            if (read_accept) begin
                if (i_read_count == '0) o_error   <= 1'b1;
                else                    remaining <= i_read_count;
            end

            if (step) begin
                if (!phase_ok) begin
                    o_error <= 1'b1;
                end else begin
                    case (i_phases)
                        4'b0001: begin
                            if (!fifo_empty) begin
                                o_bus_nibble_out <= head.nibble;
                                o_bus_is_data    <= !head.is_cmd;
                                o_bus_clk_en     <= 1'b1;
                                state            <= WRITE;
                                o_dbg_valid      <= 1'b1;
                                o_dbg_action     <= {1'b0, head.is_cmd};
                                o_dbg_data       <= head.nibble;
                            end else if (remaining != '0) begin
                                o_bus_is_data <= 1'b1;
                                o_bus_clk_en  <= 1'b1;
                                state         <= READ;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        4'b0010: o_bus_clk_en <= 1'b0;
                        4'b0100: begin
                            if (state == READ && remaining != '0) begin
                                o_read_data  <= i_bus_nibble_in;
                                o_read_valid <= 1'b1;
                                remaining    <= remaining - 1'b1;
                                o_dbg_valid  <= 1'b1;
                                o_dbg_action <= 2'b10;
                                o_dbg_data   <= i_bus_nibble_in;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/saturn_bus_sequencer.md
Name: saturn_bus_sequencer

Overview:
Parametrised successor to the Saturn bus controller. Runs the 4-phase nibble bus cycle from two sources:
- a real program FIFO (valid/ready), replacing the shared-address comparison with the control unit;
- a counted burst-read engine, which delivers read nibbles to the core with a valid strobe.

It sits between the control unit and the external bus, and emits one-cycle debugger events.

Parameters:
PTR_W, 4, FIFO depth = 2**PTR_W entries of 5 bits {is_cmd, nibble}; PTR_W >= 1
CNT_W, 5, width of burst read count; max burst = 2**CNT_W-1 nibbles

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_clk_en  in  1  global clock enable
i_stall  in  1  freeze phase actions (ALU busy / debug cycle)
i_phases  in  4  one-hot phase indicator 0001,0010,0100,1000
i_prog_valid  in  1  program entry offered
i_prog_data  in  5  [4]=command, [3:0]=nibble
o_prog_ready  out  1  FIFO not full
i_read_req  in  1  burst read request
i_read_count  in  CNT_W  nibbles to read
o_read_ready  out  1  no burst outstanding
o_read_valid  out  1  read nibble strobe, one clock
o_read_data  out  4  read nibble
i_bus_nibble_in  in  4  bus input nibble
o_bus_clk_en  out  1  bus strobe
o_bus_is_data  out  1  1=data, 0=command
o_bus_nibble_out  out  4  bus output nibble
o_busy  out  1  work pending
o_error  out  1  sticky protocol error
o_dbg_valid  out  1  debugger event strobe
o_dbg_action  out  2  00 data write, 01 cmd write, 10 read, 11 none
o_dbg_data  out  4  event nibble

Behaviour:

Clocking and reset
- One clock, i_clk. Reset is synchronous and active-high on i_reset. It has priority over everything.
- Reset values: FIFO empty, remaining=0, state IDLE. o_prog_ready=1, o_read_ready=1. o_bus_clk_en=0, o_bus_is_data=0, o_bus_nibble_out=0. o_read_valid=0, o_read_data=0. o_error=0, o_busy=0. o_dbg_valid=0, o_dbg_action=11, o_dbg_data=0.
- Reset in mid-cycle: o_bus_clk_en=0 and the FIFO is flushed at the same edge.

FIFO and read request handshakes
- FIFO push on any edge where i_prog_valid && o_prog_ready, independent of i_clk_en.
- o_prog_ready = !full, computed from registered occupancy. A push while full is refused even if a pop happens on the same edge.
- Read request accepted when i_read_req && o_read_ready; this loads remaining=i_read_count.
- i_read_count=0 on request: request ignored, o_error set.
- o_read_ready = (remaining==0).

Phase stepping
- step = i_clk_en && !i_stall.
- Phase actions occur only on step. Outputs hold their values otherwise, including o_bus_clk_en.
- step with i_phases not one-hot: no action, o_error set.

Phase actions
- 0001:
  - FIFO non-empty: pop; o_bus_nibble_out=data[3:0]; o_bus_is_data=!data[4]; o_bus_clk_en=1; state WRITE; debug event action {0,data[4]}, data=nibble.
  - Else if remaining>0: o_bus_is_data=1; o_bus_clk_en=1; state READ.
  - Else: state IDLE.
  - Writes always take priority over reads.
- 0010: o_bus_clk_en=0.
- 0100, state READ: o_read_data=i_bus_nibble_in; o_read_valid=1 for one clock; remaining decrements by 1; debug event action 10 with the read nibble.
- 1000: no action.

Debug and status outputs
- o_dbg_valid and o_read_valid are single-clock pulses.
- When no debug event occurs, o_dbg_action=11 and o_dbg_data=0.
- o_busy = FIFO non-empty || remaining!=0 || o_bus_clk_en.
- o_error stays set until reset.

Test Plan:
- Reset, push {1,5},{0,A},{0,3}, run 3 unstalled bus cycles -> o_bus_nibble_out 5,A,3 in order; o_bus_is_data 0,1,1; dbg_action 01,00,00; o_busy low after cycle 3.
- Push 2**PTR_W entries with no phases -> o_prog_ready drops after the 16th push; a 17th push while full in the same edge as a pop is refused; FIFO order is preserved.
- Read request count=3, bus drives 7,8,9 during phase 0100 -> three o_read_valid pulses with data 7,8,9; o_read_ready returns to 1 after the third.
- FIFO holding 1 entry plus read count=2 -> bus cycle 1 is the write; cycles 2-3 are reads.
- Assert i_stall during phase 0010 for 5 clocks -> o_bus_clk_en stays 1 until the first unstalled 0010; no nibble is lost or duplicated.
- i_phases=0011 with step asserted, or read count=0 -> o_error=1 and stays 1; i_reset clears it and flushes a half-full FIFO.
